// File: rtl/mcpu_ram_upload_pkg.sv
// Shared main-CPU memory-map definitions for the RAM upload (hiscore/NVRAM save) path.
// Holds the upload FSM encoding and the default hiscore window.
package mcpu_ram_upload_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_LO  = 3'd1,
    ST_RD_HI  = 3'd2,
    ST_CAP_HI = 3'd3,
    ST_OOW    = 3'd4
  } state_e;

  localparam logic [26:0] HS_BASE = 27'h0000000;
  localparam logic [26:0] HS_SIZE = 27'h0004000;

  // Uploads are word oriented: odd byte addresses fold onto the even byte below.
  function automatic logic [26:0] align_word(input logic [26:0] addr);
    return addr & ~27'h0000001;
  endfunction

endpackage

// File: rtl/mcpu_ram_upload_if.sv
// Framework ioctl upload bus: the framework is master, the RAM upload block is slave.
interface mcpu_ram_upload_if;
  logic        ioctl_upload;
  logic [26:0] ioctl_addr;
  logic        ioctl_rd;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_addr, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_addr, ioctl_rd,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/mcpu_ram_upload.sv
// Serves ioctl upload reads from a byte-wide RAM read port as little-endian 16-bit words.
// Two back-to-back byte reads per word; addresses outside the window return 16'hFFFF.
module mcpu_ram_upload
  import mcpu_ram_upload_pkg::*;
#(
  parameter int          AW   = 14,
  parameter logic [26:0] BASE = HS_BASE,
  parameter logic [26:0] SIZE = HS_SIZE
) (
  input  logic             clk_sys,
  input  logic             reset,
  mcpu_ram_upload_if.slave bus,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd,
  input  logic [7:0]       mem_q,
  output logic             busy,
  output logic             upload_done
);

  state_e        state_r, state_nxt;
  logic [15:0]   din_r, din_nxt;
  logic          wait_r, wait_nxt;
  logic [AW-1:0] addr_r, addr_nxt;
  logic          rd_r, rd_nxt;
  logic [7:0]    lo_r, lo_nxt;
  logic          hi_oow_r, hi_oow_nxt;
  logic [26:0]   word_r, word_nxt;
  logic          busy_r, upload_d_r, done_r;

  logic [26:0]   aligned_s, word_s;
  logic [AW-1:0] word_lo_s;
  logic          in_win_s, start_s, abort_s, hi_oow_s;

  // Window test runs one bit wider so BASE+SIZE never wraps.
  assign aligned_s = align_word(bus.ioctl_addr);
  assign in_win_s  = ({1'b0, aligned_s} >= {1'b0, BASE}) &&
                     ({1'b0, aligned_s} < ({1'b0, BASE} + {1'b0, SIZE}));
  assign word_s    = aligned_s - BASE;
  assign word_lo_s = word_s[AW-1:0];
  assign start_s   = bus.ioctl_rd & bus.ioctl_upload;
  assign abort_s   = (state_r != ST_IDLE) & ~bus.ioctl_upload;
  assign hi_oow_s  = ({1'b0, word_r} + 28'd1) >= {1'b0, SIZE};

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt;
  end

  // Next-state logic; a dropped upload session overrides every transition.
  always_comb begin
    state_nxt = state_r;
    if (abort_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) state_nxt = in_win_s ? ST_RD_LO : ST_OOW;
          else         state_nxt = ST_IDLE;
        end
        ST_RD_LO:  state_nxt = ST_RD_HI;
        ST_RD_HI:  state_nxt = ST_CAP_HI;
        ST_CAP_HI: state_nxt = ST_IDLE;
        ST_OOW:    state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    din_nxt    = din_r;
    wait_nxt   = wait_r;
    addr_nxt   = addr_r;
    rd_nxt     = rd_r;
    lo_nxt     = lo_r;
    hi_oow_nxt = hi_oow_r;
    word_nxt   = word_r;
    if (abort_s) begin
      wait_nxt = 1'b0;
      rd_nxt   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s && in_win_s) begin
            word_nxt = word_s;
            addr_nxt = word_lo_s;
            rd_nxt   = 1'b1;
            wait_nxt = 1'b1;
          end else if (start_s) begin
            wait_nxt = 1'b1;
          end else begin
            wait_nxt = 1'b0;
            rd_nxt   = 1'b0;
          end
        end
        ST_RD_LO: begin
          addr_nxt = addr_r + {{(AW-1){1'b0}}, 1'b1};
          rd_nxt   = 1'b1;
        end
        ST_RD_HI: begin
          lo_nxt     = mem_q;
          rd_nxt     = 1'b0;
          hi_oow_nxt = hi_oow_s;
        end
        ST_CAP_HI: begin
          din_nxt  = {(hi_oow_r ? 8'hFF : mem_q), lo_r};
          wait_nxt = 1'b0;
        end
        ST_OOW: begin
          din_nxt  = 16'hFFFF;
          wait_nxt = 1'b0;
        end
        default: begin
          wait_nxt = 1'b0;
          rd_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      din_r    <= 16'h0000;
      wait_r   <= 1'b0;
      addr_r   <= {AW{1'b0}};
      rd_r     <= 1'b0;
      lo_r     <= 8'h00;
      hi_oow_r <= 1'b0;
      word_r   <= 27'h0000000;
      busy_r   <= 1'b0;
    end else begin
      din_r    <= din_nxt;
      wait_r   <= wait_nxt;
      addr_r   <= addr_nxt;
      rd_r     <= rd_nxt;
      lo_r     <= lo_nxt;
      hi_oow_r <= hi_oow_nxt;
      word_r   <= word_nxt;
      busy_r   <= (state_nxt != ST_IDLE);
    end
  end

  // Falling-edge detector on the upload session flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      upload_d_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      upload_d_r <= bus.ioctl_upload;
      done_r     <= upload_d_r & ~bus.ioctl_upload;
    end
  end

  assign bus.ioctl_din  = din_r;
  assign bus.ioctl_wait = wait_r;
  assign mem_addr       = addr_r;
  assign mem_rd         = rd_r;
  assign busy           = busy_r;
  assign upload_done    = done_r;

endmodule

// File: tb/tb_mcpu_ram_upload.sv
// Randomized self-checking bench for mcpu_ram_upload against a behavioural word-read model.
module tb_mcpu_ram_upload;

  localparam int          AW      = 14;
  localparam logic [26:0] TB_BASE = 27'h0000000;
  localparam logic [26:0] TB_SIZE = 27'h0004000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_q = 8'h00;
  logic          busy;
  logic          upload_done;

  logic [7:0]    ram [0:16383];
  logic [AW-1:0] log_q [$];
  int            checks = 0;
  int            errors = 0;

  mcpu_ram_upload_if bus();

  mcpu_ram_upload #(.AW(AW), .BASE(TB_BASE), .SIZE(TB_SIZE)) dut (
    .clk_sys     (clk),
    .reset       (rst),
    .bus         (bus),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .busy        (busy),
    .upload_done (upload_done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM read port plus a log of every address actually read.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_q <= ram[mem_addr];
      log_q.push_back(mem_addr);
    end
  end

  function automatic bit model_in_window(input logic [26:0] addr);
    longint al;
    al = longint'(addr) - (longint'(addr) % 2);
    return (al >= longint'(TB_BASE)) && (al < longint'(TB_BASE) + longint'(TB_SIZE));
  endfunction

  function automatic logic [15:0] model_word(input logic [26:0] addr);
    longint al, off;
    logic [7:0] lo, hi;
    if (!model_in_window(addr)) return 16'hFFFF;
    al  = longint'(addr) - (longint'(addr) % 2);
    off = al - longint'(TB_BASE);
    lo  = ram[int'(off)];
    hi  = (off + 1 < longint'(TB_SIZE)) ? ram[int'(off + 1)] : 8'hFF;
    return {hi, lo};
  endfunction

  // Strobe one request at the current negedge, then wait for ioctl_wait to drop.
  task automatic do_read(input logic [26:0] addr, output logic [15:0] din, output int lat);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    lat = 1;
    while (bus.ioctl_wait === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    din = bus.ioctl_din;
  endtask

  task automatic check_read(input string name, input logic [26:0] addr);
    logic [15:0] din, exp;
    int lat, exp_lat;
    logic [AW-1:0] a;
    exp     = model_word(addr);
    exp_lat = model_in_window(addr) ? 4 : 2;
    log_q.delete();
    do_read(addr, din, lat);
    checks++;
    if (din !== exp) begin
      errors++;
      $display("FAIL %s din addr=%h got %h want %h", name, addr, din, exp);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency addr=%h got %0d want %0d", name, addr, lat, exp_lat);
    end
    checks++;
    if (model_in_window(addr)) begin
      a = AW'((longint'(addr) - longint'(TB_BASE)) & ~longint'(1));
      if (log_q.size() != 2 || log_q[0] !== a || log_q[1] !== a + AW'(1)) begin
        errors++;
        $display("FAIL %s mem_addr seq addr=%h got %0d reads first %h want %h,%h",
                 name, addr, log_q.size(), (log_q.size() > 0) ? log_q[0] : '0, a, a + AW'(1));
      end
    end else if (log_q.size() != 0) begin
      errors++;
      $display("FAIL %s oow mem_rd addr=%h got %0d reads want 0", name, addr, log_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ioctl_din !== 16'h0000 || bus.ioctl_wait !== 1'b0 || mem_addr !== '0 ||
        mem_rd !== 1'b0 || busy !== 1'b0 || upload_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got din=%h wait=%b addr=%h rd=%b busy=%b done=%b want all 0",
               bus.ioctl_din, bus.ioctl_wait, mem_addr, mem_rd, busy, upload_done);
    end
    rst = 1'b0;
    bus.ioctl_upload = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ram[0] = 8'h12; ram[1] = 8'h34;
    checks++;
    if (model_word(27'h0) !== 16'h3412) begin
      errors++;
      $display("FAIL basic_model got %h want 3412", model_word(27'h0));
    end
    check_read("basic", 27'h0000000);
    ram[2] = 8'hAB; ram[3] = 8'hCD;
    check_read("odd", 27'h0000003);
  endtask

  task automatic test_boundary();
    check_read("last_word", 27'h0003FFE);
    check_read("last_odd", 27'h0003FFF);
    check_read("first_oow", 27'h0004000);
    check_read("oow_odd", 27'h0004001);
    check_read("top_addr", 27'h7FFFFFF);
  endtask

  task automatic test_random();
    logic [26:0] addr;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) addr = 27'($urandom);
      else                           addr = 27'($urandom_range(0, 32'h47FF));
      check_read("random", addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din, exp;
    int lat;
    exp = model_word(27'h0000100);
    log_q.delete();
    bus.ioctl_addr = 27'h0000100;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(negedge clk);
    bus.ioctl_addr = 27'h0000200;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    lat = 3;
    while (bus.ioctl_wait === 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    din = bus.ioctl_din;
    repeat (4) @(negedge clk);
    checks++;
    if (din !== exp || lat !== 4) begin
      errors++;
      $display("FAIL ignored_rd got din=%h lat=%0d want %h lat=4", din, lat, exp);
    end
    checks++;
    if (log_q.size() != 2 || log_q[0] !== AW'(14'h100)) begin
      errors++;
      $display("FAIL ignored_rd reads got %0d want 2 starting 100", log_q.size());
    end
    log_q.delete();
    bus.ioctl_upload = 1'b0;
    bus.ioctl_addr   = 27'h0000010;
    bus.ioctl_rd     = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ioctl_wait !== 1'b0 || busy !== 1'b0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL rd_no_upload got wait=%b busy=%b reads=%0d want 0 0 0",
               bus.ioctl_wait, busy, log_q.size());
    end
    bus.ioctl_upload = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [15:0] prev;
    int lat;
    do_read(27'h0000010, prev, lat);
    bus.ioctl_addr = 27'h0000020;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(negedge clk);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.ioctl_wait !== 1'b0 || mem_rd !== 1'b0 ||
        bus.ioctl_din !== model_word(27'h0000010) || upload_done !== 1'b1) begin
      errors++;
      $display("FAIL abort got busy=%b wait=%b rd=%b din=%h done=%b want 0 0 0 %h 1",
               busy, bus.ioctl_wait, mem_rd, bus.ioctl_din, upload_done, model_word(27'h0000010));
    end
    @(negedge clk);
    checks++;
    if (upload_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %b want 0", upload_done);
    end
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (upload_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_on_rise got done=%b busy=%b want 0 0", upload_done, busy);
    end
  endtask

  task automatic test_async_reset();
    ram[0] = 8'h12; ram[1] = 8'h34;
    check_read("pre_reset", 27'h0000000);
    bus.ioctl_addr = 27'h0000100;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL rd_hi_busy got busy=%b rd=%b want 1 1", busy, mem_rd);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.ioctl_wait !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0 || bus.ioctl_din !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset got wait=%b rd=%b busy=%b din=%h want 0 0 0 0000",
               bus.ioctl_wait, mem_rd, busy, bus.ioctl_din);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_read("post_reset", 27'h0000000);
  endtask

  initial begin
    bus.ioctl_upload = 1'b0;
    bus.ioctl_addr   = 27'h0000000;
    bus.ioctl_rd     = 1'b0;
    for (int i = 0; i < 16384; i++) ram[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
